// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, single-outstanding instruction-memory
// read and instruction register, driven by a two-state IDLE/WAIT controller.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              jmp,
    input  logic              jmpz,
    input  logic              z,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [IR_W-1:0]   imem_data,
    output logic [IR_W-1:0]   IR,
    output logic              ir_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              rd_issue;
    logic              jump_taken;

    assign jump_taken = jmp | (jmpz & z);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        rd_issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A taken jump pre-empts a simultaneous fetch request.
                if (jump_taken) begin
                    pc_d = jmp_addr;
                end else if (fetch_req) begin
                    rd_issue = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                ir_d       = imem_data;
                pc_d       = pc_q + ADDR_W'(1);
                ir_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Strobe is masked by reset so memory sees no read while the block is held.
    assign imem_rd   = rd_issue & ~rst;
    assign imem_addr = pc_q;
    assign IR        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign busy      = (state_q == StWait);
    assign pc        = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table in IDLE plus hand-written
// sequences; fetched instructions are checked through an expected-result queue.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        jmp;
    logic        jmpz;
    logic        z;
    logic [7:0]  jmp_addr;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic [7:0]  pc;

    instr_fetch_unit #(.ADDR_W(8), .IR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .jmp       (jmp),
        .jmpz      (jmpz),
        .z         (z),
        .jmp_addr  (jmp_addr),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .imem_data (imem_data),
        .IR        (ir),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .pc        (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data appears one cycle after the read strobe.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
        else         imem_data <= 16'hDEAD;
    end

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every ir_valid pulse must match the oldest expected fetch.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (ir_valid) begin
            check("ir_valid not consecutive", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected ir_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("IR on ir_valid", {16'd0, ir}, {16'd0, e.ir});
                check("pc on ir_valid", {24'd0, pc}, {24'd0, e.pc});
            end
        end
        prev_valid = ir_valid;
    end

    typedef struct {
        string      name;
        logic       fr;
        logic       j;
        logic       jz;
        logic       zf;
        logic [7:0] ja;
        logic       exp_rd;
        logic [7:0] exp_pc;
    } vec_t;

    logic [7:0] cur_pc;

    // One IDLE-cycle vector; when a read is expected, also runs the WAIT cycle.
    task automatic apply(input vec_t v);
        fetch_req = v.fr; jmp = v.j; jmpz = v.jz; z = v.zf; jmp_addr = v.ja;
        #1;
        check({v.name, " imem_rd"}, {31'd0, imem_rd}, {31'd0, v.exp_rd});
        if (v.exp_rd) begin
            check({v.name, " imem_addr"}, {24'd0, imem_addr}, {24'd0, cur_pc});
            exp_q.push_back('{ir: mem[cur_pc], pc: v.exp_pc});
        end
        @(negedge clk);
        fetch_req = 1'b0; jmp = 1'b0; jmpz = 1'b0; z = 1'b0;
        if (v.exp_rd) begin
            check({v.name, " busy in WAIT"}, {31'd0, busy}, 32'd1);
            #1;
            check({v.name, " no rd in WAIT"}, {31'd0, imem_rd}, 32'd0);
            @(negedge clk);
        end
        check({v.name, " busy idle"}, {31'd0, busy}, 32'd0);
        check({v.name, " pc"}, {24'd0, pc}, {24'd0, v.exp_pc});
        cur_pc = v.exp_pc;
    endtask

    vec_t vecs[11];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        mem[8'h00] = 16'h0011;
        mem[8'h01] = 16'h00A1;
        mem[8'h02] = 16'h00A2;
        mem[8'h03] = 16'h00A3;
        mem[8'h40] = 16'h4040;
        mem[8'h10] = 16'h1010;
        mem[8'hFF] = 16'hBEEF;

        vecs[0]  = '{"fetch0",        1, 0, 0, 0, 8'h00, 1, 8'h01};
        vecs[1]  = '{"jmpz z0",       0, 0, 1, 0, 8'h40, 0, 8'h01};
        vecs[2]  = '{"jmpz z1",       0, 0, 1, 1, 8'h40, 0, 8'h40};
        vecs[3]  = '{"fetch40",       1, 0, 0, 0, 8'h00, 1, 8'h41};
        vecs[4]  = '{"jmp+fetch",     1, 1, 0, 0, 8'h10, 0, 8'h10};
        vecs[5]  = '{"fetch10",       1, 0, 0, 0, 8'h00, 1, 8'h11};
        vecs[6]  = '{"jmpz0+fetch",   1, 0, 1, 0, 8'h77, 1, 8'h12};
        vecs[7]  = '{"idle",          0, 0, 0, 1, 8'h33, 0, 8'h12};
        vecs[8]  = '{"jmpFF",         0, 1, 0, 0, 8'hFF, 0, 8'hFF};
        vecs[9]  = '{"fetchFF wrap",  1, 0, 0, 0, 8'h00, 1, 8'h00};
        vecs[10] = '{"jmpz1+fetch",   1, 0, 1, 1, 8'h01, 0, 8'h01};

        // Reset state, with fetch_req high to confirm the strobe is masked.
        rst = 1'b1; fetch_req = 1'b1; jmp = 1'b0; jmpz = 1'b0; z = 1'b0; jmp_addr = 8'h00;
        @(negedge clk);
        check("reset pc", {24'd0, pc}, 32'd0);
        check("reset IR", {16'd0, ir}, 32'd0);
        check("reset ir_valid", {31'd0, ir_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset imem_rd", {31'd0, imem_rd}, 32'd0);
        rst = 1'b0; fetch_req = 1'b0;
        cur_pc = 8'h00;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i]);

        // Back-to-back: fetch_req held, reads every other cycle from pc=1.
        exp_q.push_back('{ir: 16'h00A1, pc: 8'h02});
        exp_q.push_back('{ir: 16'h00A2, pc: 8'h03});
        exp_q.push_back('{ir: 16'h00A3, pc: 8'h04});
        fetch_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("b2b imem_rd", {31'd0, imem_rd}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check("b2b imem_addr", {24'd0, imem_addr}, 32'(1 + i / 2));
            @(negedge clk);
        end
        fetch_req = 1'b0;
        check("b2b final pc", {24'd0, pc}, 32'h04);

        // Requests and jumps during WAIT are dropped, not queued.
        fetch_req = 1'b1;
        #1;
        check("wait-ign imem_rd", {31'd0, imem_rd}, 32'd1);
        exp_q.push_back('{ir: mem[8'h04], pc: 8'h05});
        @(negedge clk);
        jmp = 1'b1; jmpz = 1'b1; z = 1'b1; jmp_addr = 8'h80;
        @(negedge clk);
        fetch_req = 1'b0; jmp = 1'b0; jmpz = 1'b0; z = 1'b0;
        check("wait-ign pc", {24'd0, pc}, 32'h05);
        #1;
        check("wait-ign no queued rd", {31'd0, imem_rd}, 32'd0);
        @(negedge clk);
        check("wait-ign pc held", {24'd0, pc}, 32'h05);
        check("wait-ign busy", {31'd0, busy}, 32'd0);

        // Reset during WAIT aborts the fetch: nothing is pushed for it.
        fetch_req = 1'b1;
        #1;
        check("abort imem_rd", {31'd0, imem_rd}, 32'd1);
        @(negedge clk);
        fetch_req = 1'b0;
        check("abort busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort pc", {24'd0, pc}, 32'd0);
        check("abort IR", {16'd0, ir}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort IR held", {16'd0, ir}, 32'd0);
        cur_pc = 8'h00;
        apply('{"fetch after rst", 1, 0, 0, 0, 8'h00, 1, 8'h01});

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
